// File: rtl/mac_rx_frame.sv
// GMII receive framer: strips preamble/SFD, checks CRC-32 and length, and streams
// the frame with the 4 FCS bytes removed using a 5-byte delay line.
module mac_rx_frame #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522
) (
    input  logic        mac_rxc,
    input  logic        rst,
    input  logic        mac_rxv,
    input  logic [7:0]  mac_rxd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_good,
    output logic [10:0] rx_len,
    output logic [15:0] rx_err_cnt
);

    typedef enum logic [1:0] {S_WAIT, S_IDLE, S_PRE, S_DATA} state_t;

    localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    state_t          state_q, state_d;
    logic [4:0][7:0] dly_q;
    logic [31:0]     crc_q;
    logic [10:0]     cnt_q;
    logic            first_q;
    logic [7:0]      data_q;
    logic            valid_q, sof_q, eof_q, good_q;
    logic [10:0]     len_q;
    logic [15:0]     err_q;

    logic byte_acc, frame_end, sfd_seen, full, good_chk;

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: if (!mac_rxv) state_d = S_IDLE;
            S_IDLE: if (mac_rxv && mac_rxd == 8'h55) state_d = S_PRE;
            S_PRE: begin
                if (!mac_rxv)                state_d = S_IDLE;
                else if (mac_rxd == 8'hD5)   state_d = S_DATA;
                else if (mac_rxd != 8'h55)   state_d = S_WAIT;
            end
            S_DATA: if (!mac_rxv) state_d = S_IDLE;
            default: state_d = S_WAIT;
        endcase
    end

    assign byte_acc  = (state_q == S_DATA) && mac_rxv;
    assign frame_end = (state_q == S_DATA) && !mac_rxv;
    assign sfd_seen  = (state_q == S_PRE) && mac_rxv && (mac_rxd == 8'hD5);
    // Five bytes held means the oldest one can no longer be part of the FCS.
    assign full      = (cnt_q >= 11'd5);
    assign good_chk  = (crc_q == RESIDUE) && (cnt_q >= MIN_L) && (cnt_q <= MAX_L);

    always_ff @(posedge mac_rxc or posedge rst) begin
        if (rst) begin
            state_q <= S_WAIT;
            dly_q   <= '0;
            crc_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            good_q  <= 1'b0;
            len_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= 1'b0;
            if (sfd_seen) begin
                crc_q   <= 32'hFFFFFFFF;
                cnt_q   <= '0;
                first_q <= 1'b1;
            end
            if (byte_acc) begin
                dly_q <= {dly_q[3:0], mac_rxd};
                crc_q <= crc_step(crc_q, mac_rxd);
                if (cnt_q != 11'h7FF) cnt_q <= cnt_q + 11'd1;
                if (full) begin
                    valid_q <= 1'b1;
                    data_q  <= dly_q[4];
                    sof_q   <= first_q;
                    eof_q   <= 1'b0;
                    first_q <= 1'b0;
                end
            end
            if (frame_end) begin
                if (full) begin
                    valid_q <= 1'b1;
                    data_q  <= dly_q[4];
                    sof_q   <= first_q;
                    eof_q   <= 1'b1;
                    good_q  <= good_chk;
                    len_q   <= cnt_q - 11'd4;
                    first_q <= 1'b0;
                    if (!good_chk && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
                end else if (err_q != 16'hFFFF) begin
                    err_q <= err_q + 16'd1;
                end
            end
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign rx_sof     = sof_q;
    assign rx_eof     = eof_q;
    assign rx_good    = good_q;
    assign rx_len     = len_q;
    assign rx_err_cnt = err_q;

endmodule

// File: doc/mac_rx_frame.md
MAC_RX_FRAME -- requirements
Module: mac_rx_frame

Interface
REQ-001 Parameter: MIN_LEN, default 64, minimum good frame length in bytes after SFD including FCS.
REQ-002 Parameter: MAX_LEN, default 1522, maximum good frame length in bytes after SFD including FCS.
REQ-003 Port: mac_rxc  input  1  GMII receive clock; every register in the block is clocked on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: mac_rxv  input  1  GMII receive valid, synchronous to mac_rxc.
REQ-006 Port: mac_rxd  input  8  GMII receive byte, sampled only when mac_rxv=1.
REQ-007 Port: rx_data  output  8  frame byte after SFD, with the FCS removed.
REQ-008 Port: rx_valid  output  1  rx_data is valid this cycle.
REQ-009 Port: rx_sof  output  1  first byte of the frame, qualified by rx_valid.
REQ-010 Port: rx_eof  output  1  last byte of the frame, qualified by rx_valid.
REQ-011 Port: rx_good  output  1  frame passed all checks; meaningful only when rx_eof=1.
REQ-012 Port: rx_len  output  11  payload byte count excluding FCS; meaningful only when rx_eof=1.
REQ-013 Port: rx_err_cnt  output  16  count of bad or discarded frames, saturating.

Function
REQ-014 The state machine SHALL have four states: WAIT, IDLE, PRE, DATA.
REQ-015 WAIT SHALL go to IDLE on the first cycle with mac_rxv=0.
REQ-016 IDLE SHALL go to PRE when mac_rxv=1 and mac_rxd=0x55; it SHALL otherwise stay in IDLE.
REQ-017 PRE SHALL stay in PRE on mac_rxv=1 with 0x55, SHALL go to DATA on mac_rxv=1 with 0xD5, SHALL go to WAIT on mac_rxv=1 with any other byte, and SHALL go to IDLE on mac_rxv=0; none of these transitions SHALL produce output or change the counters.
REQ-018 In DATA, each byte with mac_rxv=1 SHALL shift into a 5-byte delay line, update a CRC-32 register, and increment an 11-bit byte counter that saturates at 2047.
REQ-019 CRC-32 SHALL use the reflected polynomial 0xEDB88320, be initialised to 0xFFFFFFFF on SFD, and process LSB first with no final XOR.
REQ-020 The CRC check SHALL pass when the register equals 0xDEBB20E3 after the last byte, which is FCS byte 3.
REQ-021 Once the delay line holds 5 bytes, each newly accepted byte SHALL cause the oldest byte to be output one cycle later with rx_valid=1.
REQ-022 rx_sof=1 SHALL accompany the first byte output for a frame.
REQ-023 The first cycle in DATA with mac_rxv=0 SHALL end the frame and return the machine to IDLE.
REQ-024 At frame end with at least 5 bytes received, the oldest held byte (the last payload byte) SHALL be output one cycle later with rx_valid=1 and rx_eof=1.
REQ-025 At that same rx_eof cycle, rx_len SHALL equal the byte count minus 4, and the 4 FCS bytes SHALL never be output.
REQ-026 rx_good SHALL be 1 only when the CRC check passes, the byte count is at least MIN_LEN, and the byte count is at most MAX_LEN.
REQ-027 When rx_eof=1 and rx_good=0, rx_err_cnt SHALL increment by 1.
REQ-028 A frame with fewer than 5 bytes after SFD SHALL produce no output and SHALL increment rx_err_cnt by 1.
REQ-029 A single-byte frame SHALL assert rx_sof and rx_eof in the same cycle.
REQ-030 rx_err_cnt SHALL saturate at 0xFFFF.
REQ-031 Every output SHALL be registered; rx_data, rx_sof, rx_eof, rx_good and rx_len SHALL hold their value when rx_valid=0.
REQ-032 A frame whose byte count exceeds MAX_LEN SHALL still be streamed in full, ending with rx_good=0.
REQ-033 rx_valid SHALL never assert on two consecutive frames without at least one cycle between them.

Reset
REQ-034 While rst=1: state=WAIT; rx_valid, rx_sof, rx_eof and rx_good = 0; rx_data=0x00; rx_len=0; rx_err_cnt=0; delay line, CRC and byte counter cleared.
REQ-035 Reset taking effect mid-frame SHALL discard the rest of that frame, because the machine leaves WAIT only after mac_rxv=0.
REQ-036 A frame truncated by reset SHALL not be counted in rx_err_cnt.

Verification
REQ-037 7x0x55, 0xD5, then 60 payload bytes 0x00..0x3B with a correct FCS -> 60 rx_valid cycles, sof on 0x00, eof on 0x3B, rx_len=60, rx_good=1, rx_err_cnt=0.
REQ-038 The same frame with FCS byte 0 XOR 0x01 -> 60 bytes output, rx_good=0, rx_err_cnt=1.
REQ-039 Preamble followed by 0x5D instead of 0xD5, then 64 bytes -> no rx_valid, machine goes to WAIT and then IDLE after mac_rxv=0.
REQ-040 SFD followed by 3 bytes, then mac_rxv=0 -> no rx_valid, rx_err_cnt increments by 1.
REQ-041 rst pulse at payload byte 20 of a 100-byte frame -> outputs are 0 and no output appears until the next frame, which is received with rx_good=1.
REQ-042 Two back-to-back good frames separated by 1 idle cycle -> both received with rx_good=1; sof/eof of the two frames do not overlap.
